// File: rtl/crossy_pkg.sv
// crossy_pkg: shared constants and types for the road-crossing game.
//   ScreenWidth/CarWidth/CarHeight : sprite geometry in pixels
//   TravelDist                     : distance a car covers before it is fully off-screen
//   car_type_t                     : sprite selector (CAR_0..CAR_2)
//   spawner_state_t                : lane_spawner FSM states
package crossy_pkg;

  localparam int unsigned ScreenWidth = 640;
  localparam int unsigned CarWidth    = 48;
  localparam int unsigned CarHeight   = 26;
  localparam int unsigned TravelDist  = ScreenWidth + CarWidth;

  typedef enum logic [1:0] {CAR_0, CAR_1, CAR_2} car_type_t;

  typedef enum logic [1:0] {IDLE, WAIT, ACTIVE} spawner_state_t;

  // Random 2-bit value to sprite type; the unused code 3 folds onto CAR_0.
  function automatic car_type_t map_type(logic [1:0] raw);
    return (raw == 2'd3) ? CAR_0 : car_type_t'(raw);
  endfunction

  // Random 3-bit value to speed; a stationary car is never produced.
  function automatic logic [2:0] map_speed(logic [2:0] raw);
    return (raw == 3'd0) ? 3'd1 : raw;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
//   FrameClk : clock
//   Reset    : asynchronous active-high reset, loads Seed (0 replaced by 1)
//   Enable   : advance one step on this edge
//   Q        : current register value
module lfsr16 #(
  parameter logic [15:0] Seed = 16'hACE1
) (
  input  logic        FrameClk,
  input  logic        Reset,
  input  logic        Enable,
  output logic [15:0] Q
);

  // An all-zero LFSR would lock up forever.
  localparam logic [15:0] SeedSafe = (Seed == 16'h0000) ? 16'h0001 : Seed;

  logic [15:0] q_q;
  logic        feedback;

  assign feedback = q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10];

  always_ff @(posedge FrameClk or posedge Reset) begin
    if (Reset) begin
      q_q <= SeedSafe;
    end else if (Enable) begin
      q_q <= {q_q[14:0], feedback};
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/lane_spawner.sv
// lane_spawner: traffic controller for one road lane. Decides when a car
// appears, its sprite type and speed, tracks its travelled distance and
// retires it once it has crossed the screen.
//   FrameClk    : frame-rate clock
//   Reset       : asynchronous active-high reset
//   GameEnable  : 1 = run, 0 = freeze every register
//   SpawnEnable : car present and moving
//   FaceLeft    : constant LeftBound
//   Type        : sprite type 0..2
//   Speed       : pixels per frame 1..7
//   SpawnY      : constant LaneY
// Build option: define SPEED_RAMP_EN to add a speed floor that rises by one
// after every 8th completed car (saturating at 7).
module lane_spawner
  import crossy_pkg::*;
#(
  parameter logic [9:0]  LaneY     = 10'd0,
  parameter logic        LeftBound = 1'b0,
  parameter logic [7:0]  MinGap    = 8'd10,
  parameter logic [15:0] Seed      = 16'hACE1
) (
  input  logic       FrameClk,
  input  logic       Reset,
  input  logic       GameEnable,
  output logic       SpawnEnable,
  output logic       FaceLeft,
  output logic [1:0] Type,
  output logic [2:0] Speed,
  output logic [9:0] SpawnY
);

  localparam logic [10:0] TravelDist11 = 11'(TravelDist);

  spawner_state_t state_q, state_d;
  logic [8:0]     gap_cnt_q, gap_cnt_d;
  logic [10:0]    dist_q, dist_d;
  car_type_t      type_q, type_d;
  logic [2:0]     speed_q, speed_d;

  logic [15:0]    lfsr;
  logic [8:0]     new_gap;
  logic [10:0]    dist_sum;
  logic           at_end;
  logic [2:0]     spawn_speed;
  logic           unused_lfsr;

  lfsr16 #(
    .Seed (Seed)
  ) u_lfsr (
    .FrameClk (FrameClk),
    .Reset    (Reset),
    .Enable   (GameEnable),
    .Q        (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:10];

  assign new_gap  = {1'b0, MinGap} + {4'b0, lfsr[9:5]};
  assign dist_sum = dist_q + {8'b0, speed_q};
  assign at_end   = (dist_sum >= TravelDist11);

`ifdef SPEED_RAMP_EN
  logic [2:0] car_cnt_q;
  logic [2:0] floor_q;
  logic [2:0] lfsr_speed;
  logic       car_done;

  assign lfsr_speed  = map_speed(lfsr[4:2]);
  assign spawn_speed = (lfsr_speed < floor_q) ? floor_q : lfsr_speed;
  assign car_done    = GameEnable && (state_q == ACTIVE) && at_end;

  always_ff @(posedge FrameClk or posedge Reset) begin
    if (Reset) begin
      car_cnt_q <= 3'd0;
      floor_q   <= 3'd1;
    end else if (car_done) begin
      car_cnt_q <= car_cnt_q + 3'd1;
      // car_cnt_q wrapping from 7 marks the 8th completed car.
      if ((car_cnt_q == 3'd7) && (floor_q != 3'd7)) begin
        floor_q <= floor_q + 3'd1;
      end
    end
  end
`else
  assign spawn_speed = map_speed(lfsr[4:2]);
`endif

  always_ff @(posedge FrameClk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      gap_cnt_q <= 9'd0;
      dist_q    <= 11'd0;
      type_q    <= CAR_0;
      speed_q   <= 3'd1;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      dist_q    <= dist_d;
      type_q    <= type_d;
      speed_q   <= speed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    dist_d    = dist_q;
    type_d    = type_q;
    speed_d   = speed_q;
    if (GameEnable) begin
      case (state_q)
        IDLE: begin
          state_d   = WAIT;
          gap_cnt_d = new_gap;
        end
        WAIT: begin
          // A zero gap (MinGap 0, random part 0) spawns on the next edge too.
          if (gap_cnt_q <= 9'd1) begin
            state_d   = ACTIVE;
            gap_cnt_d = 9'd0;
            type_d    = map_type(lfsr[1:0]);
            speed_d   = spawn_speed;
            dist_d    = 11'd0;
          end else begin
            gap_cnt_d = gap_cnt_q - 9'd1;
          end
        end
        ACTIVE: begin
          if (at_end) begin
            state_d   = WAIT;
            gap_cnt_d = new_gap;
            dist_d    = 11'd0;
          end else begin
            dist_d = dist_sum;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Derived from the state register so an asynchronous reset drops it at once.
  assign SpawnEnable = (state_q == ACTIVE);
  assign FaceLeft    = LeftBound;
  assign Type        = type_q;
  assign Speed       = speed_q;
  assign SpawnY      = LaneY;

endmodule
